// File: rtl/soric_pkg.sv
// rtl/soric_pkg.sv - shared types and defaults for the soric Wishbone arbiter
package soric_pkg;

  localparam int WB_AW       = 32;
  localparam int WB_DW       = 32;
  localparam int ARB_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/soric_wb_timeout.sv
// rtl/soric_wb_timeout.sv - stall counter that pulses expire on the TIMEOUT-th stalled cycle
module soric_wb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry ignores clr_i so a late ack in the abort cycle cannot cancel the error.
  assign expire_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!en_i || clr_i || expire_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/soric_wb_arbiter.sv
// rtl/soric_wb_arbiter.sv - two-master round-robin Wishbone arbiter with cycle lock and
// bus-error timeout in front of soric_core
module soric_wb_arbiter
  import soric_pkg::*;
#(
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic [DW-1:0]   m0_dat_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [DW-1:0]   m1_dat_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic            s_ack_i,
  input  logic [DW-1:0]   s_dat_i,
  output logic [1:0]      grant_o,
  output logic            timeout_o
);

  arb_state_e state_q, state_d;
  logic       last_grant_q, last_grant_d;

  logic            mux_cyc, mux_stb, mux_we;
  logic [DW/8-1:0] mux_sel;
  logic [AW-1:0]   mux_adr;
  logic [DW-1:0]   mux_dat;
  logic            pending, expire, ack_fwd, err_fwd;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_grant_q ? ARB_GNT0 : ARB_GNT1;
        end else if (m0_cyc_i) begin
          state_d = ARB_GNT0;
        end else if (m1_cyc_i) begin
          state_d = ARB_GNT1;
        end
      end
      ARB_GNT0: begin
        if (!m0_cyc_i) begin
          state_d      = ARB_IDLE;
          last_grant_d = 1'b0;
        end
      end
      ARB_GNT1: begin
        if (!m1_cyc_i) begin
          state_d      = ARB_IDLE;
          last_grant_d = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    mux_cyc = 1'b0;
    mux_stb = 1'b0;
    mux_we  = 1'b0;
    mux_sel = '0;
    mux_adr = '0;
    mux_dat = '0;
    case (state_q)
      ARB_GNT0: begin
        mux_cyc = m0_cyc_i;
        mux_stb = m0_stb_i;
        mux_we  = m0_we_i;
        mux_sel = m0_sel_i;
        mux_adr = m0_adr_i;
        mux_dat = m0_dat_i;
      end
      ARB_GNT1: begin
        mux_cyc = m1_cyc_i;
        mux_stb = m1_stb_i;
        mux_we  = m1_we_i;
        mux_sel = m1_sel_i;
        mux_adr = m1_adr_i;
        mux_dat = m1_dat_i;
      end
      default: ;
    endcase
  end

  assign pending = (state_q != ARB_IDLE) && mux_stb;

  soric_wb_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_ni),
    .en_i    (pending),
    .clr_i   (s_ack_i),
    .expire_o(expire)
  );

  // Responses are suppressed while reset is asserted so an aborted transfer ends silently.
  assign ack_fwd = s_ack_i && !expire && wb_rst_ni;
  assign err_fwd = expire && wb_rst_ni;

  assign s_cyc_o   = mux_cyc;
  assign s_stb_o   = mux_stb && !expire;
  assign s_we_o    = mux_we;
  assign s_sel_o   = mux_sel;
  assign s_adr_o   = mux_adr;
  assign s_dat_o   = mux_dat;

  assign m0_ack_o  = (state_q == ARB_GNT0) && ack_fwd;
  assign m0_err_o  = (state_q == ARB_GNT0) && err_fwd;
  assign m1_ack_o  = (state_q == ARB_GNT1) && ack_fwd;
  assign m1_err_o  = (state_q == ARB_GNT1) && err_fwd;
  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;

  assign grant_o   = {state_q == ARB_GNT1, state_q == ARB_GNT0};
  assign timeout_o = err_fwd;

endmodule
